// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: direction encoding,
// screen geometry defaults and pixel colours.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int START_X_DEF  = 80;
    localparam int START_Y_DEF  = 60;
    localparam int BLOCK_SIZE   = 2;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_SNAKE = 3'b010;

    // The encoding pairs opposites so that flipping bit 0 reverses a direction.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Step pacing counter: go pulses for one cycle every TICKS_PER_STEP cycles.
// clr restarts the count; hold freezes it and masks go.
module rate_divider #(
    parameter int TICKS_PER_STEP = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic go
);

    localparam int CW = $clog2(TICKS_PER_STEP);
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

    logic [CW-1:0] tick_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
        end else if (!hold) begin
            if (tick_cnt == LAST) tick_cnt <= '0;
            else                  tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign go = (tick_cnt == LAST) && !hold;

endmodule

// File: rtl/snake_datapath.sv
// Snake head position/direction, 2x2 block plotting and step pacing.
// Define SNAKE_WRAP_EN to make the head wrap at screen edges instead of dying.
module snake_datapath
    import snake_pkg::*;
#(
    parameter int         SCREEN_W       = SCREEN_W_DEF,
    parameter int         SCREEN_H       = SCREEN_H_DEF,
    parameter int         START_X        = START_X_DEF,
    parameter int         START_Y        = START_Y_DEF,
    parameter int         TICKS_PER_STEP = 12500000,
    parameter logic [2:0] SNAKE_COLOUR   = COLOUR_SNAKE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic       update,
    input  logic       plot,
    input  logic [1:0] dir_in,
    output logic       go,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       write_en,
    output logic       dead
);

    // Strobe protocol: ld, update and plot are level samples taken every
    // cycle with no backpressure; ld dominates, go is a fire-and-forget pulse.

    localparam logic [8:0] X_MAX   = 9'(SCREEN_W - BLOCK_SIZE);
    localparam logic [7:0] Y_MAX   = 8'(SCREEN_H - BLOCK_SIZE);
    localparam logic [7:0] X_START = 8'(START_X);
    localparam logic [6:0] Y_START = 7'(START_Y);
    localparam logic [8:0] STEP_X  = 9'(BLOCK_SIZE);
    localparam logic [7:0] STEP_Y  = 8'(BLOCK_SIZE);

    dir_t       dir;
    logic [7:0] head_x;
    logic [6:0] head_y;
    logic [1:0] pix_cnt;
    logic [8:0] step_x;
    logic [7:0] step_y;
    logic       off_x;
    logic       off_y;
    logic       hit;
    logic [7:0] next_x;
    logic [6:0] next_y;

    // One extra bit: a borrow shows up as the MSB, an overshoot as > MAX.
    always_comb begin
        step_x = {1'b0, head_x};
        step_y = {1'b0, head_y};
        case (dir)
            DIR_UP:    step_y = {1'b0, head_y} - STEP_Y;
            DIR_DOWN:  step_y = {1'b0, head_y} + STEP_Y;
            DIR_LEFT:  step_x = {1'b0, head_x} - STEP_X;
            DIR_RIGHT: step_x = {1'b0, head_x} + STEP_X;
            default:   ;
        endcase
        off_x = step_x[8] || (step_x > X_MAX);
        off_y = step_y[7] || (step_y > Y_MAX);
`ifdef SNAKE_WRAP_EN
        hit    = 1'b0;
        next_x = off_x ? (step_x[8] ? X_MAX[7:0] : 8'd0) : step_x[7:0];
        next_y = off_y ? (step_y[7] ? Y_MAX[6:0] : 7'd0) : step_y[6:0];
`else
        hit    = off_x || off_y;
        next_x = hit ? head_x : step_x[7:0];
        next_y = hit ? head_y : step_y[6:0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_x <= X_START;
            head_y <= Y_START;
            dir    <= DIR_RIGHT;
            dead   <= 1'b0;
        end else if (ld) begin
            head_x <= X_START;
            head_y <= Y_START;
            dir    <= DIR_RIGHT;
            dead   <= 1'b0;
        end else begin
            if (dir_t'(dir_in) != opposite(dir)) dir <= dir_t'(dir_in);
            if (update) begin
                head_x <= next_x;
                head_y <= next_y;
                if (hit) dead <= 1'b1;
            end
        end
    end

    // Pixels come from the head as it stands during the plot cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt    <= 2'd0;
            x_out      <= 8'd0;
            y_out      <= 7'd0;
            colour_out <= COLOUR_BLACK;
            write_en   <= 1'b0;
        end else if (ld) begin
            pix_cnt  <= 2'd0;
            write_en <= 1'b0;
        end else if (plot) begin
            pix_cnt    <= pix_cnt + 2'd1;
            x_out      <= head_x + {7'd0, pix_cnt[0]};
            y_out      <= head_y + {6'd0, pix_cnt[1]};
            colour_out <= SNAKE_COLOUR;
            write_en   <= 1'b1;
        end else begin
            pix_cnt  <= 2'd0;
            write_en <= 1'b0;
        end
    end

    rate_divider #(
        .TICKS_PER_STEP(TICKS_PER_STEP)
    ) u_rate_divider (
        .clk  (clk),
        .rst  (rst),
        .clr  (ld),
        .hold (dead),
        .go   (go)
    );

endmodule

// File: tb/tb_snake_datapath.sv
// Directed bench for snake_datapath with a short step period.
// Define SNAKE_WRAP_EN for both bench and RTL to check the wrapping build.
module tb_snake_datapath;
    import snake_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld = 1'b0;
    logic       update = 1'b0;
    logic       plot = 1'b0;
    logic [1:0] dir_in = 2'b11;
    logic       go;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       write_en;
    logic       dead;

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q[$];

    typedef struct {
        logic [1:0] dir;
        int         n;
        logic [7:0] ex;
        logic [6:0] ey;
    } move_t;
    move_t moves[6];

    snake_datapath #(
        .TICKS_PER_STEP(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld         (ld),
        .update     (update),
        .plot       (plot),
        .dir_in     (dir_in),
        .go         (go),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .write_en   (write_en),
        .dead       (dead)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver and checking tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_ld();
        ld = 1'b1;
        tick();
        ld = 1'b0;
    endtask

    task automatic do_update(input logic [1:0] d, input int n);
        dir_in = d;
        tick();
        update = 1'b1;
        repeat (n) tick();
        update = 1'b0;
    endtask

    task automatic push_block(input logic [7:0] x, input logic [6:0] y);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] lx;
            logic [6:0] ly;
            lx = x + 8'(i & 1);
            ly = y + 7'(i >> 1);
            exp_q.push_back({lx, ly, 3'b010});
        end
    endtask

    task automatic plot_burst(input logic [7:0] x, input logic [6:0] y);
        logic [17:0] exp;
        push_block(x, y);
        plot = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) plot = 1'b0;
            check("burst_write_en", 32'(write_en), 32'd1);
            if (exp_q.size() == 0) begin
                check("burst_queue_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                exp = exp_q.pop_front();
                check("burst_pixel", 32'({x_out, y_out, colour_out}), 32'(exp));
            end
        end
        tick();
        check("burst_end_write_en", 32'(write_en), 32'd0);
    endtask

    initial begin
        int goes;
        int seen;

        moves[0] = '{2'b10, 1, 8'd82, 7'd60};  // LEFT while RIGHT: ignored
        moves[1] = '{2'b00, 1, 8'd82, 7'd58};  // UP
        moves[2] = '{2'b01, 1, 8'd82, 7'd56};  // DOWN while UP: ignored
        moves[3] = '{2'b10, 2, 8'd78, 7'd56};  // LEFT
        moves[4] = '{2'b01, 3, 8'd78, 7'd62};  // DOWN
        moves[5] = '{2'b11, 1, 8'd80, 7'd62};  // RIGHT

        // Reset state
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_go", 32'(go), 32'd0);
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_x", 32'(x_out), 32'd0);
        check("rst_y", 32'(y_out), 32'd0);
        check("rst_colour", 32'(colour_out), 32'd0);
        check("rst_dead", 32'(dead), 32'd0);
        rst = 1'b1;

        // go pacing after release: pulse when the count reaches 3
        check("go_k0", 32'(go), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("go_k%0d", k), 32'(go), (k % 4 == 3) ? 32'd1 : 32'd0);
            check("idle_write_en", 32'(write_en), 32'd0);
        end

        // Start position after ld
        do_ld();
        plot_burst(8'd80, 7'd60);

        // Table of moves, each followed by a block plot at the new head
        foreach (moves[m]) begin
            do_update(moves[m].dir, moves[m].n);
            plot_burst(moves[m].ex, moves[m].ey);
        end

        // ld and update together
        dir_in = 2'b11;
        ld = 1'b1;
        update = 1'b1;
        tick();
        ld = 1'b0;
        update = 1'b0;
        plot_burst(8'd80, 7'd60);
        check("ld_update_dead", 32'(dead), 32'd0);

        // Right edge
        do_update(2'b11, 39);
        plot_burst(8'd158, 7'd60);
        do_update(2'b11, 1);
`ifdef SNAKE_WRAP_EN
        check("wrap_dead", 32'(dead), 32'd0);
        plot_burst(8'd0, 7'd60);
`else
        check("edge_dead", 32'(dead), 32'd1);
        goes = 0;
        repeat (20) begin
            tick();
            if (go) goes++;
        end
        check("go_while_dead", 32'(goes), 32'd0);
        check("dead_sticky", 32'(dead), 32'd1);
        plot_burst(8'd158, 7'd60);
        do_ld();
        check("ld_clears_dead", 32'(dead), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (go) seen = 1;
            tick();
        end
        check("go_resumes", 32'(seen), 32'd1);
`endif

        // Asynchronous reset in the middle of a burst
        do_update(2'b00, 1);
        plot = 1'b1;
        tick();
        tick();
        check("mid_burst_write_en", 32'(write_en), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("async_write_en", 32'(write_en), 32'd0);
        check("async_x", 32'(x_out), 32'd0);
        check("async_y", 32'(y_out), 32'd0);
        check("async_colour", 32'(colour_out), 32'd0);
        check("async_go", 32'(go), 32'd0);
        check("async_dead", 32'(dead), 32'd0);
        plot = 1'b0;
        dir_in = 2'b11;
        tick();
        rst = 1'b1;
        tick();
        plot_burst(8'd80, 7'd60);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
